data_streamer: RTL and testbench
================================

DATA_STREAMER -- requirements
Module: data_streamer

Interface
REQ-001 Parameter ADDR_W, default 18, SHALL set the memory address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the memory word width and SHALL be a multiple of 8 (BYTES = DATA_W/8).
REQ-003 Parameter RD_LAT, default 1, range 1..4, SHALL set the memory read latency in cycles.
REQ-004 clk  in  1  sole clock; all logic on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  asynchronous active-low button; a synchronised falling edge requests a transfer.
REQ-007 abort  in  1  synchronous active-high; cancels any transfer.
REQ-008 loop  in  1  sampled at trigger; 1 = repeat the range until abort.
REQ-009 start_addr  in  ADDR_W  first word address, latched at trigger.
REQ-010 end_addr  in  ADDR_W  last word address (inclusive), latched at trigger.
REQ-011 mem_addr  out  ADDR_W  memory read address.
REQ-012 mem_ren  out  1  one-cycle read strobe.
REQ-013 mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after the mem_ren cycle.
REQ-014 tx_data  out  8  byte to the transmitter.
REQ-015 tx_valid  out  1  tx_data is valid.
REQ-016 tx_ready  in  1  transmitter accepts a byte when tx_ready and tx_valid are both 1.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse when a non-loop transfer completes.
REQ-019 err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-020 The block SHALL pass start through two flops (s1, s2); the trigger is s1==0 && s2==1, evaluated only in IDLE. Triggers in any other state SHALL be ignored.
REQ-021 The FSM SHALL have the states IDLE, FETCH, WAIT, SEND and DONE.
REQ-022 IDLE, on trigger: if start_addr > end_addr, pulse err and remain in IDLE; otherwise latch the addresses and loop, and go to FETCH on the next cycle.
REQ-023 FETCH SHALL assert mem_ren for exactly one cycle with mem_addr = the current address, then go to WAIT.
REQ-024 WAIT SHALL count RD_LAT cycles, capture mem_rdata into the serialiser, then go to SEND.
REQ-025 SEND SHALL present bytes MSB-first, with tx_valid=1 from the first SEND cycle.
REQ-026 While tx_valid=1 and tx_ready=0, tx_data SHALL be held stable.
REQ-027 Each accepted byte SHALL advance to the next byte in the cycle after acceptance; with tx_ready held high, throughput SHALL be one byte per cycle.
REQ-028 After the last byte of a word is accepted:
- If address ≠ end_addr: increment the address and go to FETCH.
- Else if loop=1: reload start_addr and go to FETCH.
- Else: go to DONE.
REQ-029 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-030 The end check SHALL compare before incrementing, so end_addr = all-ones SHALL NOT wrap or re-read address 0.
REQ-031 start_addr == end_addr SHALL transfer exactly one word (BYTES bytes).
REQ-032 abort=1 in any non-IDLE state SHALL, on the next edge:
- clear tx_valid and mem_ren;
- enter IDLE with no done pulse;
- leave any byte not yet accepted untransmitted.
REQ-033 If abort and tx acceptance occur in the same cycle, the byte SHALL count as sent and abort SHALL still take effect.
REQ-034 A trigger and abort in the same IDLE cycle: abort SHALL win and no transfer SHALL start.
REQ-035 tx_valid SHALL never be asserted outside SEND.
REQ-036 mem_ren SHALL never be asserted outside FETCH.

Reset
REQ-037 rst_n=0 SHALL immediately force the FSM to IDLE and clear all outputs: mem_addr=0, mem_ren=0, tx_data=0, tx_valid=0, busy=0, done=0, err=0.
REQ-038 rst_n=0 SHALL set s1=s2=1 (button released) and clear the internal counters.
REQ-039 Reset asserted mid-transfer SHALL abandon the transfer without a done pulse; the first trigger after release SHALL start a fresh transfer.

Structure
REQ-040 Package data_streamer_pkg SHALL hold the FSM state enumeration and the constant BYTE_W = 8.
REQ-041 One sub-module, word_serializer, SHALL:
- load a DATA_W word;
- shift bytes out MSB-first under the valid/ready rule;
- flag the last byte.
REQ-042 The FSM, start synchroniser and address counter SHALL reside in data_streamer.

Verification
REQ-043 DATA_W=8, start_addr=0, end_addr=3, tx_ready=1, memory returns addr+0x10 → bytes 10,11,12,13; one done pulse; busy falls the cycle after done.
REQ-044 DATA_W=32, start_addr=end_addr=5, mem[5]=0xA1B2C3D4, tx_ready toggling 1-of-3 cycles → A1,B2,C3,D4, each held stable while not accepted.
REQ-045 ADDR_W=4, start_addr=14, end_addr=15 → exactly two reads (addresses 14 and 15), no read at 0, done pulses.
REQ-046 start_addr=7, end_addr=2 → err pulses for 1 cycle, busy stays 0, no mem_ren.
REQ-047 loop=1, range 0..1 → sequence 0,1,0,1,… continues; abort after the 5th byte → tx_valid=0 next cycle, no done.
REQ-048 rst_n pulsed low during SEND → all outputs 0 asynchronously; a later start falling edge restarts from start_addr.

Source files
------------

// File: rtl/data_streamer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// data_streamer_pkg : shared FSM state type and byte width.  Rev 1.0
// ---------------------------------------------------------------------------
package data_streamer_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/data_streamer_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// word_serializer : splits a DATA_W word into bytes, MSB first, valid/ready.
// Rev 1.0
// ---------------------------------------------------------------------------
module word_serializer
  import data_streamer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [DATA_W-1:0]   word_i,
  input  logic                clear_i,
  input  logic                ready_i,
  output logic [BYTE_W-1:0]   data_o,
  output logic                valid_o,
  output logic                last_o
);

  localparam int BYTES = DATA_W / BYTE_W;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_W-1:0] sh_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              valid_q;
  logic              last;
  logic              accept;

  assign last   = (cnt_q == CNT_W'(BYTES - 1));
  assign accept = valid_q & ready_i;

  // A clear in the same cycle as an acceptance still lets that byte go out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      sh_q    <= word_i;
      cnt_q   <= '0;
      valid_q <= 1'b1;
    end else if (accept) begin
      if (last) begin
        valid_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        sh_q  <= sh_q << BYTE_W;
      end
    end
  end

  assign data_o  = sh_q[DATA_W-1 -: BYTE_W];
  assign valid_o = valid_q;
  assign last_o  = last;

endmodule
`default_nettype wire

// File: rtl/data_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// data_streamer : on a start-button press, reads a memory address range and
// streams every word out byte-wise.  Rev 1.0
// ---------------------------------------------------------------------------
module data_streamer
  import data_streamer_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                loop,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_ren,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [BYTE_W-1:0]   tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_e            state_q;
  logic              s1_q, s2_q;
  logic [ADDR_W-1:0] addr_q, base_q, end_q;
  logic [ADDR_W-1:0] addr_d;
  logic              loop_q;
  logic [2:0]        lat_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_ren_q, done_q, err_q;
  logic              trigger;
  logic              ser_load, ser_clear, ser_last;

  assign trigger   = ~s1_q & s2_q;
  assign ser_load  = (state_q == WAIT) && (lat_q == LAT_LAST) && !abort;
  assign ser_clear = abort && (state_q != IDLE);

  // End check happens before the increment, so an all-ones end never wraps.
  assign addr_d = (addr_q != end_q) ? addr_q + 1'b1 : base_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      addr_q     <= '0;
      base_q     <= '0;
      end_q      <= '0;
      loop_q     <= 1'b0;
      lat_q      <= '0;
      mem_addr_q <= '0;
      mem_ren_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_q      <= start;
      s2_q      <= s1_q;
      mem_ren_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (trigger) begin
              if (start_addr > end_addr) begin
                err_q <= 1'b1;
              end else begin
                addr_q     <= start_addr;
                base_q     <= start_addr;
                end_q      <= end_addr;
                loop_q     <= loop;
                mem_addr_q <= start_addr;
                mem_ren_q  <= 1'b1;
                state_q    <= FETCH;
              end
            end
          end
          FETCH: begin
            lat_q   <= '0;
            state_q <= WAIT;
          end
          WAIT: begin
            if (lat_q == LAT_LAST) begin
              state_q <= SEND;
            end else begin
              lat_q <= lat_q + 1'b1;
            end
          end
          SEND: begin
            if (tx_valid && tx_ready && ser_last) begin
              if ((addr_q != end_q) || loop_q) begin
                addr_q     <= addr_d;
                mem_addr_q <= addr_d;
                mem_ren_q  <= 1'b1;
                state_q    <= FETCH;
              end else begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  word_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ser_load),
    .word_i  (mem_rdata),
    .clear_i (ser_clear),
    .ready_i (tx_ready),
    .data_o  (tx_data),
    .valid_o (tx_valid),
    .last_o  (ser_last)
  );

  assign mem_addr = mem_addr_q;
  assign mem_ren  = mem_ren_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_data_streamer : randomised bench with a byte/address scoreboard.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_data_streamer;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam int BYTES  = DATA_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b1;
  logic              abort = 1'b0;
  logic              loop = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ren;
  logic [DATA_W-1:0] mem_rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              busy, done, err;

  data_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop(loop),
    .start_addr(start_addr), .end_addr(end_addr), .mem_addr(mem_addr),
    .mem_ren(mem_ren), .mem_rdata(mem_rdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Memory: data is only meaningful exactly RD_LAT cycles after the strobe.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              pipe_v [RD_LAT];
  logic [ADDR_W-1:0] pipe_a [RD_LAT];
  logic [DATA_W-1:0] junk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_a[i] <= '0;
      end
      junk <= '0;
    end else begin
      pipe_v[0] <= mem_ren;
      pipe_a[0] <= mem_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
      junk <= $urandom;
    end
  end

  assign mem_rdata = pipe_v[RD_LAT-1] ? mem[pipe_a[RD_LAT-1]] : junk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the expected byte stream and read addresses of a job.
  logic [7:0]        exp_b [$];
  logic [ADDR_W-1:0] exp_a [$];
  int   n_bytes = 0, n_reads = 0, n_done = 0, n_err = 0, n_busy = 0;
  int   cyc = 0, t_ren = 0, run_len = 0, max_run = 0;
  int   rdy_mode = 0, rdy_ph = 0;
  logic pv = 1'b0, pr = 1'b0, pdone = 1'b0, perr = 1'b0;
  logic [7:0] pd = '0;

  task automatic load_job(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea, input int words);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] w;
    exp_b.delete();
    exp_a.delete();
    a = sa;
    for (int n = 0; n < words; n++) begin
      exp_a.push_back(a);
      w = mem[a];
      for (int k = BYTES - 1; k >= 0; k--) exp_b.push_back(w[k*8 +: 8]);
      a = (a == ea) ? sa : a + 1'b1;
    end
  endtask

  task automatic sample();
    cyc++;
    if (!rst_n) begin
      pv = 1'b0; pr = 1'b0; pdone = 1'b0; perr = 1'b0; run_len = 0;
      return;
    end
    if (tx_valid && tx_ready) begin
      n_bytes++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_b.size() == 0) chk("byte_expected", exp_b.size(), 1);
      else chk("tx_byte", tx_data, exp_b.pop_front());
    end else begin
      run_len = 0;
    end
    if (pv && !pr && tx_valid) chk("tx_hold", tx_data, pd);
    if (tx_valid) chk("valid_busy", busy, 1);
    if (tx_valid && !pv) chk("ren_to_valid", cyc - t_ren, RD_LAT + 1);
    if (mem_ren) begin
      n_reads++;
      t_ren = cyc;
      if (exp_a.size() == 0) chk("read_expected", exp_a.size(), 1);
      else chk("rd_addr", mem_addr, exp_a.pop_front());
    end
    if (done) begin
      n_done++;
      chk("done_busy", busy, 1);
    end
    if (pdone) chk("after_done", {done, busy}, 2'b00);
    if (err) n_err++;
    if (perr) chk("err_width", err, 0);
    if (busy) n_busy++;
    pv = tx_valid; pr = tx_ready; pd = tx_data; pdone = done; perr = err;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = (rdy_ph == 0);
    endcase
    rdy_ph = (rdy_ph + 1) % 3;
    @(negedge clk);
    sample();
  endtask

  task automatic press();
    start = 1'b0;
    repeat (4) step();
    start = 1'b1;
    repeat (2) step();
  endtask

  task automatic run(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea, input int words);
    int d0, cnt;
    start_addr = sa;
    end_addr   = ea;
    loop       = 1'b0;
    load_job(sa, ea, words);
    d0 = n_done;
    press();
    cnt = 0;
    while (n_done == d0 && cnt < 3000) begin
      step();
      cnt++;
    end
    chk("done_count", n_done - d0, 1);
    chk("bytes_left", exp_b.size(), 0);
    chk("reads_left", exp_a.size(), 0);
    repeat (2) step();
    chk("idle_after", busy, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {mem_addr, mem_ren, tx_data, tx_valid, busy, done, err}, 0);
  endtask

  initial begin
    int r0, d0, e0, b0, bb0, cnt;
    logic [ADDR_W-1:0] sa, ea;

    for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
    for (int a = 0; a < 4; a++) mem[a] = DATA_W'(a + 'h10);
    mem[5] = 32'hA1B2C3D4;

    repeat (3) @(negedge clk);
    chk_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (2) step();

    // Plain range with continuous ready.
    rdy_mode = 0;
    run(4'd0, 4'd3, 4);

    // Single word, ready 1-of-3: bytes held while stalled.
    rdy_mode = 2;
    run(4'd5, 4'd5, 1);

    // Single word at full rate: one byte per cycle.
    rdy_mode = 0;
    max_run = 0;
    run(4'd5, 4'd5, 1);
    chk("byte_per_cycle", max_run, BYTES);

    // Top of the address space must not wrap to 0.
    r0 = n_reads;
    run(4'd14, 4'd15, 2);
    chk("top_reads", n_reads - r0, 2);

    // Rejected request.
    start_addr = 4'd7; end_addr = 4'd2; loop = 1'b0;
    load_job(4'd7, 4'd2, 0);
    r0 = n_reads; e0 = n_err; b0 = n_busy;
    press();
    repeat (4) step();
    chk("err_count", n_err - e0, 1);
    chk("err_busy", n_busy - b0, 0);
    chk("err_reads", n_reads - r0, 0);

    // Trigger during abort in IDLE: nothing starts.
    start_addr = 4'd0; end_addr = 4'd3;
    load_job(4'd0, 4'd3, 0);
    r0 = n_reads; e0 = n_err; b0 = n_busy;
    abort = 1'b1;
    press();
    repeat (2) step();
    abort = 1'b0;
    repeat (6) step();
    chk("idle_abort_busy", n_busy - b0, 0);
    chk("idle_abort_reads", n_reads - r0, 0);

    // Looping range 0..1, aborted on the first byte of the fifth word.
    rdy_mode = 0;
    start_addr = 4'd0; end_addr = 4'd1; loop = 1'b1;
    load_job(4'd0, 4'd1, 8);
    r0 = n_reads; d0 = n_done; bb0 = n_bytes;
    start = 1'b0;
    cnt = 0;
    while ((n_bytes - bb0) < 4 * BYTES + 1 && cnt < 1000) begin
      step();
      cnt++;
      if (cnt == 4) start = 1'b1;
    end
    start = 1'b1;
    chk("loop_reached", n_bytes - bb0, 4 * BYTES + 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (10) step();
    chk("abort_bytes", n_bytes - bb0, 4 * BYTES + 1);
    chk("abort_done", n_done - d0, 0);
    chk("loop_reads", n_reads - r0, 5);
    loop = 1'b0;

    // Reset in the middle of SEND.
    rdy_mode = 1;
    start_addr = 4'd2; end_addr = 4'd6;
    load_job(4'd2, 4'd6, 5);
    d0 = n_done;
    start = 1'b0;
    cnt = 0;
    while (!tx_valid && cnt < 200) begin
      step();
      cnt++;
    end
    start = 1'b1;
    chk("reached_send", tx_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("async_reset");
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("reset_no_done", n_done - d0, 0);
    run(4'd2, 4'd3, 2);

    // Random ranges and ready patterns.
    for (int it = 0; it < 20; it++) begin
      for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
      rdy_mode = (it % 3 == 0) ? 0 : 1;
      sa = ADDR_W'($urandom_range(0, DEPTH - 1));
      ea = ADDR_W'($urandom_range(0, DEPTH - 1));
      if (sa <= ea) begin
        run(sa, ea, int'(ea) - int'(sa) + 1);
      end else begin
        start_addr = sa; end_addr = ea;
        load_job(sa, ea, 0);
        e0 = n_err; b0 = n_busy;
        press();
        repeat (3) step();
        chk("rand_err", n_err - e0, 1);
        chk("rand_err_busy", n_busy - b0, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
